// File: rtl/esp32_loader_pkg.sv
// Shared types and constants for the ESP32 ROM loader: FSM encodings, SPI
// address regions, cartridge header offsets and reset-time memory masks.
package esp32_loader_pkg;

    typedef enum logic [2:0] {
        M_IDLE,
        M_LOAD,
        M_FLUSH,
        M_DRAIN,
        M_DETECT,
        M_DONE
    } main_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_PULSE,
        W_GUARD,
        W_WAIT
    } wr_state_t;

    localparam logic [7:0] REGION_ROM  = 8'h00;
    localparam logic [7:0] REGION_CFG  = 8'hFE;
    localparam logic [7:0] REGION_CTRL = 8'hFF;

    // Low-byte offsets of the SNES header fields, identical for LoROM (0x7Fxx) and HiROM (0xFFxx)
    localparam logic [7:0] HDR_MODE     = 8'hD5;
    localparam logic [7:0] HDR_ROM_SIZE = 8'hD7;
    localparam logic [7:0] HDR_RAM_SIZE = 8'hD8;
    localparam logic [7:0] HDR_CMP_LO   = 8'hDC;
    localparam logic [7:0] HDR_CMP_HI   = 8'hDD;
    localparam logic [7:0] HDR_SUM_LO   = 8'hDE;
    localparam logic [7:0] HDR_SUM_HI   = 8'hDF;

    localparam logic [23:0] ROM_MASK_RST = 24'h07FFFF;
    localparam logic [23:0] RAM_MASK_RST = 24'h0007FF;

    // Header size byte n means 1 KiB << n; the exponent is clamped before shifting.
    function automatic logic [23:0] size_mask(input logic [7:0] size, input logic [7:0] cap);
        logic [7:0]  s;
        logic [31:0] m;
        s = (size > cap) ? cap : size;
        m = (32'd1024 << s) - 32'd1;
        return m[23:0];
    endfunction

endpackage

// File: rtl/loader_word_fifo.sv
// Small synchronous FIFO of {word address, data} entries between the byte
// packer and the SDRAM write sequencer; push and pop may happen together.
module loader_word_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 41
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clear,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/esp32_rom_loader.sv
// Packs ESP32 SPI byte writes into 16-bit SDRAM load writes and holds the core
// in reset while loading. Define HEADER_DETECT_EN to derive config from the ROM header.
module esp32_rom_loader
    import esp32_loader_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 25
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              spi_wr,
    input  logic [31:0]       spi_addr,
    input  logic [7:0]        spi_data,
    output logic [ADDR_W-1:0] load_addr,
    output logic [15:0]       load_data,
    output logic              load_wr,
    input  logic              load_busy,
    output logic              load_done,
    output logic              sys_reset,
    output logic [7:0]        rom_type,
    output logic [23:0]       rom_mask,
    output logic [23:0]       ram_mask,
    output logic              load_overflow
);

    localparam int EW = ADDR_W + 16;

    main_state_t       state, state_n;
    wr_state_t         wr_state, wr_state_n;
    logic              spi_wr_q, wr_edge, rom_edge, cfg_edge;
    logic              ctrl_start, ctrl_end, start_pend, start_go;
    logic [ADDR_W-1:0] word_addr;
    logic              lat_valid, lat_set, lat_clr;
    logic [ADDR_W-1:0] lat_addr;
    logic [7:0]        lat_data;
    logic              push_n, push_q;
    logic [EW-1:0]     push_word_n, push_word_q;
    logic              fifo_pop, fifo_full, fifo_empty;
    logic [EW-1:0]     fifo_head;

    assign wr_edge    = spi_wr && !spi_wr_q;
    assign rom_edge   = wr_edge && (spi_addr[31:24] == REGION_ROM);
    assign cfg_edge   = wr_edge && (spi_addr[31:24] == REGION_CFG);
    assign ctrl_start = wr_edge && (spi_addr[31:24] == REGION_CTRL) && spi_data[0];
    assign ctrl_end   = wr_edge && (spi_addr[31:24] == REGION_CTRL) && !spi_data[0];
    assign word_addr  = ADDR_W'(spi_addr[23:1]);
    // A restart may only clear the FIFO between SDRAM writes, so it is parked until then
    assign start_go   = (ctrl_start || start_pend) && (wr_state == W_IDLE);

    always_comb begin
        state_n     = state;
        push_n      = 1'b0;
        push_word_n = '0;
        lat_set     = 1'b0;
        lat_clr     = 1'b0;
        case (state)
            M_LOAD: begin
                if (ctrl_end) begin
                    state_n = M_FLUSH;
                end else if (rom_edge) begin
                    if (!spi_addr[0]) begin
                        push_n      = lat_valid;
                        push_word_n = {lat_addr, 8'hFF, lat_data};
                        lat_set     = 1'b1;
                    end else if (lat_valid && (lat_addr == word_addr)) begin
                        push_n      = 1'b1;
                        push_word_n = {word_addr, spi_data, lat_data};
                        lat_clr     = 1'b1;
                    end else begin
                        push_n      = 1'b1;
                        push_word_n = {word_addr, spi_data, 8'hFF};
                    end
                end
            end
            M_FLUSH: begin
                push_n      = lat_valid;
                push_word_n = {lat_addr, 8'hFF, lat_data};
                lat_clr     = 1'b1;
                state_n     = M_DRAIN;
            end
            M_DRAIN: begin
                if (fifo_empty && !push_q && (wr_state == W_IDLE)) state_n = M_DETECT;
            end
            M_DETECT: state_n = M_DONE;
            M_DONE:   state_n = M_IDLE;
            default:  state_n = M_IDLE;
        endcase
        if (start_go) begin
            state_n = M_LOAD;
            push_n  = 1'b0;
            lat_set = 1'b0;
            lat_clr = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= M_IDLE;
            load_done     <= 1'b0;
            sys_reset     <= 1'b1;
            spi_wr_q      <= 1'b0;
            start_pend    <= 1'b0;
            push_q        <= 1'b0;
            push_word_q   <= '0;
            lat_valid     <= 1'b0;
            lat_addr      <= '0;
            lat_data      <= '0;
            load_overflow <= 1'b0;
        end else begin
            state       <= state_n;
            load_done   <= (state_n == M_IDLE) || (state_n == M_DONE);
            sys_reset   <= !((state_n == M_IDLE) || (state_n == M_DONE));
            spi_wr_q    <= spi_wr;
            start_pend  <= start_go ? 1'b0 : (start_pend || ctrl_start);
            push_q      <= push_n;
            push_word_q <= push_word_n;
            if (lat_set) begin
                lat_valid <= 1'b1;
                lat_addr  <= word_addr;
                lat_data  <= spi_data;
            end else if (lat_clr) begin
                lat_valid <= 1'b0;
            end
            if (start_go)                               load_overflow <= 1'b0;
            else if (push_q && fifo_full && !fifo_pop) load_overflow <= 1'b1;
        end
    end

    loader_word_fifo #(.DEPTH(FIFO_DEPTH), .W(EW)) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (start_go),
        .push      (push_q),
        .push_data (push_word_q),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Handshake: load_wr is a one-cycle request issued only when a word is queued and
    // load_busy is low; load_addr/load_data hold until the next request; load_busy is
    // ignored the cycle after the request, then must drop before the next one.
    always_comb begin
        wr_state_n = wr_state;
        fifo_pop   = 1'b0;
        case (wr_state)
            W_IDLE:  if (!fifo_empty && !load_busy && !start_go) wr_state_n = W_PULSE;
            W_PULSE: begin
                fifo_pop   = 1'b1;
                wr_state_n = W_GUARD;
            end
            W_GUARD: wr_state_n = W_WAIT;
            W_WAIT:  if (!load_busy) wr_state_n = W_IDLE;
            default: wr_state_n = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_state  <= W_IDLE;
            load_addr <= '0;
            load_data <= '0;
        end else begin
            wr_state <= wr_state_n;
            if ((wr_state == W_IDLE) && (wr_state_n == W_PULSE)) begin
                load_addr <= fifo_head[EW-1:16];
                load_data <= fifo_head[15:0];
            end
        end
    end

    assign load_wr = (wr_state == W_PULSE);

`ifdef HEADER_DETECT_EN
    logic [7:0] hdr_rom_sz [2];
    logic [7:0] hdr_ram_sz [2];
    logic [7:0] hdr_cmp_lo [2];
    logic [7:0] hdr_cmp_hi [2];
    logic [7:0] hdr_sum_lo [2];
    logic [7:0] hdr_sum_hi [2];
    logic [1:0] hdr_valid;
    logic       hdr_hit;
    logic       hirom;

    // Bank 0 is the LoROM header at 0x7Fxx, bank 1 the HiROM header at 0xFFxx
    assign hdr_hit = (state == M_LOAD) && rom_edge && (spi_addr[23:16] == 8'h00)
                     && (spi_addr[14:8] == 7'h7F);
    assign hirom   = hdr_valid[1] && !hdr_valid[0];

    always_comb begin
        for (int b = 0; b < 2; b++) begin
            hdr_valid[b] = (({hdr_cmp_hi[b], hdr_cmp_lo[b]} ^ {hdr_sum_hi[b], hdr_sum_lo[b]}) == 16'hFFFF);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int b = 0; b < 2; b++) begin
                hdr_rom_sz[b] <= '0; hdr_ram_sz[b] <= '0;
                hdr_cmp_lo[b] <= '0; hdr_cmp_hi[b] <= '0;
                hdr_sum_lo[b] <= '0; hdr_sum_hi[b] <= '0;
            end
        end else if (start_go) begin
            for (int b = 0; b < 2; b++) begin
                hdr_rom_sz[b] <= '0; hdr_ram_sz[b] <= '0;
                hdr_cmp_lo[b] <= '0; hdr_cmp_hi[b] <= '0;
                hdr_sum_lo[b] <= '0; hdr_sum_hi[b] <= '0;
            end
        end else if (hdr_hit) begin
            case (spi_addr[7:0])
                HDR_ROM_SIZE: hdr_rom_sz[spi_addr[15]] <= spi_data;
                HDR_RAM_SIZE: hdr_ram_sz[spi_addr[15]] <= spi_data;
                HDR_CMP_LO:   hdr_cmp_lo[spi_addr[15]] <= spi_data;
                HDR_CMP_HI:   hdr_cmp_hi[spi_addr[15]] <= spi_data;
                HDR_SUM_LO:   hdr_sum_lo[spi_addr[15]] <= spi_data;
                HDR_SUM_HI:   hdr_sum_hi[spi_addr[15]] <= spi_data;
                default: ;
            endcase
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_type <= '0;
            rom_mask <= ROM_MASK_RST;
            ram_mask <= RAM_MASK_RST;
        end else begin
            if (cfg_edge) begin
                case (spi_addr[23:0])
                    24'd0: rom_type       <= spi_data;
                    24'd1: rom_mask[7:0]   <= spi_data;
                    24'd2: rom_mask[15:8]  <= spi_data;
                    24'd3: rom_mask[23:16] <= spi_data;
                    24'd4: ram_mask[7:0]   <= spi_data;
                    24'd5: ram_mask[15:8]  <= spi_data;
                    24'd6: ram_mask[23:16] <= spi_data;
                    default: ;
                endcase
            end
`ifdef HEADER_DETECT_EN
            if ((state == M_DETECT) && (hdr_valid != 2'b00)) begin
                rom_type <= {7'b0, hirom};
                rom_mask <= size_mask(hdr_rom_sz[hirom], 8'd14);
                ram_mask <= (hdr_ram_sz[hirom] == 8'd0) ? 24'd0 : size_mask(hdr_ram_sz[hirom], 8'd10);
            end
`endif
        end
    end

endmodule

// File: tb/tb_esp32_rom_loader.sv
// Self-checking bench for esp32_rom_loader: directed loads, randomized byte
// streams against a byte-pairing reference model, overflow, reset and config.
module tb_esp32_rom_loader;

    localparam int ADDR_W = 25;
    localparam int EW     = ADDR_W + 16;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              spi_wr = 1'b0;
    logic [31:0]       spi_addr = '0;
    logic [7:0]        spi_data = '0;
    logic              load_busy = 1'b0;
    logic [ADDR_W-1:0] load_addr;
    logic [15:0]       load_data;
    logic              load_wr;
    logic              load_done;
    logic              sys_reset;
    logic [7:0]        rom_type;
    logic [23:0]       rom_mask;
    logic [23:0]       ram_mask;
    logic              load_overflow;

    esp32_rom_loader #(.FIFO_DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .spi_wr        (spi_wr),
        .spi_addr      (spi_addr),
        .spi_data      (spi_data),
        .load_addr     (load_addr),
        .load_data     (load_data),
        .load_wr       (load_wr),
        .load_busy     (load_busy),
        .load_done     (load_done),
        .sys_reset     (sys_reset),
        .rom_type      (rom_type),
        .rom_mask      (rom_mask),
        .ram_mask      (ram_mask),
        .load_overflow (load_overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] got_q[$];
    logic [23:0]   byte_a[$];
    logic [7:0]    byte_d[$];
    int cyc = 0;
    int last_wr = -100;
    int spacing_viol = 0;

    // Monitor: record every SDRAM write request and its spacing
    always @(negedge clk) begin
        cyc++;
        if (reset_n && load_wr) begin
            if (cyc - last_wr < 3) spacing_viol++;
            last_wr = cyc;
            got_q.push_back({load_addr, load_data});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: pair each odd byte with the preceding even byte of the same word;
    // unpaired bytes are completed with 0xFF.
    function automatic void model_load();
        bit                pv = 0;
        logic [ADDR_W-1:0] pw = '0;
        logic [7:0]        pd = '0;
        logic [ADDR_W-1:0] wa;
        for (int i = 0; i < byte_a.size(); i++) begin
            wa = ADDR_W'(byte_a[i] >> 1);
            if (byte_a[i] % 2 == 0) begin
                if (pv) exp_q.push_back({pw, 8'hFF, pd});
                pv = 1; pw = wa; pd = byte_d[i];
            end else if (pv && pw == wa) begin
                exp_q.push_back({wa, byte_d[i], pd});
                pv = 0;
            end else begin
                exp_q.push_back({wa, byte_d[i], 8'hFF});
            end
        end
        if (pv) exp_q.push_back({pw, 8'hFF, pd});
    endfunction

    task automatic spi_write(input logic [31:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        spi_addr = a; spi_data = d; spi_wr = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        spi_wr = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic rom_byte(input logic [23:0] a, input logic [7:0] d);
        byte_a.push_back(a);
        byte_d.push_back(d);
        spi_write({8'h00, a}, d);
    endtask

    task automatic start_load();
        byte_a.delete();
        byte_d.delete();
        spi_write(32'hFF00_0000, 8'h01);
    endtask

    task automatic end_load();
        spi_write(32'hFF00_0000, 8'h00);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (load_done !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (load_done !== 1'b1) begin
            failures++;
            $display("FAIL %s_done_timeout: load_done=%b expected 1", name, load_done);
        end
    endtask

    task automatic compare_words(input string name);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL %s_count: got %0d writes expected %0d", name, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL %s_word%0d: got addr=%h data=%h expected addr=%h data=%h", name, i,
                         got_q[i][EW-1:16], got_q[i][15:0], exp_q[i][EW-1:16], exp_q[i][15:0]);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({load_done, sys_reset, load_wr, load_overflow} !== 4'b0100) begin
            failures++;
            $display("FAIL reset_ctrl: done/sysrst/wr/ovf=%b expected 0100",
                     {load_done, sys_reset, load_wr, load_overflow});
        end
        checks++;
        if (load_addr !== '0 || load_data !== 16'h0) begin
            failures++;
            $display("FAIL reset_bus: addr=%h data=%h expected 0 0", load_addr, load_data);
        end
        checks++;
        if (rom_type !== 8'h00 || rom_mask !== 24'h07FFFF || ram_mask !== 24'h0007FF) begin
            failures++;
            $display("FAIL reset_cfg: type=%h rom=%h ram=%h expected 00 07ffff 0007ff",
                     rom_type, rom_mask, ram_mask);
        end
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (load_done !== 1'b1 || sys_reset !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: done=%b sysrst=%b expected 1 0", load_done, sys_reset);
        end
    endtask

    task automatic test_basic();
        start_load();
        checks++;
        if (load_done !== 1'b0 || sys_reset !== 1'b1) begin
            failures++;
            $display("FAIL basic_loading: done=%b sysrst=%b expected 0 1", load_done, sys_reset);
        end
        rom_byte(24'd0, 8'h11);
        rom_byte(24'd1, 8'h22);
        rom_byte(24'd2, 8'h33);
        rom_byte(24'd3, 8'h44);
        end_load();
        exp_q.push_back({25'd0, 16'h2211});
        exp_q.push_back({25'd1, 16'h4433});
        wait_done("basic");
        compare_words("basic");
        start_load();
        rom_byte(24'd4, 8'hAA);
        end_load();
        exp_q.push_back({25'd2, 16'hFFAA});
        wait_done("odd_len");
        compare_words("odd_len");
    endtask

    task automatic test_config();
        spi_write(32'hFE00_0001, 8'hFF);
        spi_write(32'hFE00_0002, 8'hFF);
        spi_write(32'hFE00_0003, 8'h0F);
        spi_write(32'hFE00_0004, 8'h3F);
        spi_write(32'hFE00_0005, 8'h00);
        @(posedge clk); #1;
        spi_addr = 32'hFE00_0000; spi_data = 8'h5A; spi_wr = 1'b1;
        @(negedge clk);
        checks++;
        if (rom_type !== 8'h00) begin
            failures++;
            $display("FAIL cfg_before_edge: rom_type=%h expected 00", rom_type);
        end
        @(negedge clk);
        checks++;
        if (rom_type !== 8'h5A) begin
            failures++;
            $display("FAIL cfg_after_edge: rom_type=%h expected 5a", rom_type);
        end
        @(posedge clk); #1;
        spi_wr = 1'b0;
        checks++;
        if (rom_mask !== 24'h0FFFFF || ram_mask !== 24'h00003F) begin
            failures++;
            $display("FAIL cfg_masks: rom=%h ram=%h expected 0fffff 00003f", rom_mask, ram_mask);
        end
        start_load();
        for (int i = 0; i < 6; i++) rom_byte(24'(i + 8), 8'($urandom_range(0, 255)));
        end_load();
        model_load();
        wait_done("cfg_load");
        compare_words("cfg_load");
        checks++;
        if (rom_type !== 8'h5A || rom_mask !== 24'h0FFFFF || ram_mask !== 24'h00003F) begin
            failures++;
            $display("FAIL cfg_kept: type=%h rom=%h ram=%h expected 5a 0fffff 00003f",
                     rom_type, rom_mask, ram_mask);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            int n;
            logic [23:0] a;
            n = $urandom_range(3, 12);
            a = 24'($urandom_range(0, 40));
            start_load();
            for (int i = 0; i < n; i++) begin
                rom_byte(a, 8'($urandom_range(0, 255)));
                a = a + 24'($urandom_range(0, 3));
            end
            end_load();
            model_load();
            wait_done("random");
            compare_words("random");
        end
        checks++;
        if (spacing_viol != 0) begin
            failures++;
            $display("FAIL wr_spacing: %0d pulses closer than 3 cycles expected 0", spacing_viol);
        end
    endtask

    task automatic test_overflow();
        load_busy = 1'b1;
        start_load();
        for (int i = 0; i < 12; i++) rom_byte(24'(i), 8'($urandom_range(0, 255)));
        model_load();
        while (exp_q.size() > DEPTH) void'(exp_q.pop_back());
        checks++;
        if (got_q.size() != 0) begin
            failures++;
            $display("FAIL ovf_busy_hold: got %0d writes while busy expected 0", got_q.size());
        end
        checks++;
        if (load_overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_flag: load_overflow=%b expected 1", load_overflow);
        end
        end_load();
        repeat (20) @(posedge clk);
        #1 load_busy = 1'b0;
        wait_done("ovf");
        compare_words("ovf");
        start_load();
        checks++;
        if (load_overflow !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clear: load_overflow=%b expected 0", load_overflow);
        end
        end_load();
        wait_done("ovf_empty");
        compare_words("ovf_empty");
    endtask

    task automatic test_midload_reset();
        load_busy = 1'b1;
        start_load();
        rom_byte(24'd0, 8'h01);
        rom_byte(24'd1, 8'h02);
        rom_byte(24'd3, 8'h04);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({load_wr, sys_reset, load_done, load_overflow} !== 4'b0100) begin
            failures++;
            $display("FAIL midrst_ctrl: wr/sysrst/done/ovf=%b expected 0100",
                     {load_wr, sys_reset, load_done, load_overflow});
        end
        checks++;
        if (rom_mask !== 24'h07FFFF || rom_type !== 8'h00) begin
            failures++;
            $display("FAIL midrst_cfg: rom=%h type=%h expected 07ffff 00", rom_mask, rom_type);
        end
        @(negedge clk);
        reset_n = 1'b1;
        load_busy = 1'b0;
        @(negedge clk);
        checks++;
        if (load_done !== 1'b1) begin
            failures++;
            $display("FAIL midrst_done: load_done=%b expected 1", load_done);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (got_q.size() != 0) begin
            failures++;
            $display("FAIL midrst_fifo_empty: got %0d writes expected 0", got_q.size());
        end
        got_q.delete();
    endtask

    task automatic test_header();
        logic [7:0]  e_type;
        logic [23:0] e_rom, e_ram;
`ifdef HEADER_DETECT_EN
        e_type = 8'h01; e_rom = 24'h3FFFFF; e_ram = 24'h001FFF;
`else
        e_type = 8'h00; e_rom = 24'h07FFFF; e_ram = 24'h0007FF;
`endif
        start_load();
        rom_byte(24'h00FFD7, 8'h0C);
        rom_byte(24'h00FFD8, 8'h03);
        rom_byte(24'h00FFDC, 8'hCB);
        rom_byte(24'h00FFDD, 8'hED);
        rom_byte(24'h00FFDE, 8'h34);
        rom_byte(24'h00FFDF, 8'h12);
        end_load();
        model_load();
        wait_done("header");
        compare_words("header");
        checks++;
        if (rom_type !== e_type || rom_mask !== e_rom || ram_mask !== e_ram) begin
            failures++;
            $display("FAIL header_cfg: type=%h rom=%h ram=%h expected %h %h %h",
                     rom_type, rom_mask, ram_mask, e_type, e_rom, e_ram);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_config();
        test_random();
        test_overflow();
        test_midload_reset();
        test_header();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
